// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared constants, state type and bit-timing helper for the boot image sender
package boot_pkg;

  localparam logic [7:0] SYNC_BYTE0 = 8'hA5;
  localparam logic [7:0] SYNC_BYTE1 = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HEADER   = 3'd1,
    ST_DATA     = 3'd2,
    ST_CHECKSUM = 3'd3,
    ST_FINISH   = 3'd4
  } state_t;

  // Rounded-to-nearest number of clocks per UART bit.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 transmitter that accepts the next byte in the last stop-bit cycle
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       ready,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

  logic          r_active;
  logic          r_tx;
  logic [CW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [8:0]    r_shift;

  logic w_bit_end;
  logic w_stop_end;

  assign w_bit_end  = (r_baud == LAST_TICK);
  assign w_stop_end = r_active && w_bit_end && (r_bit == 4'd9);
  // Ready during the final stop cycle so back-to-back bytes have no idle gap.
  assign ready      = !r_active || w_stop_end;
  assign tx         = r_tx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_tx     <= 1'b1;
      r_baud   <= '0;
      r_bit    <= 4'd0;
      r_shift  <= 9'h1FF;
    end else if (load && ready) begin
      r_active <= 1'b1;
      r_tx     <= 1'b0;
      r_baud   <= '0;
      r_bit    <= 4'd0;
      r_shift  <= {1'b1, byte_in};
    end else if (r_active) begin
      if (w_bit_end) begin
        r_baud <= '0;
        if (r_bit == 4'd9) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
          r_bit   <= r_bit + 4'd1;
        end
      end else begin
        r_baud <= r_baud + 1'b1;
      end
    end
  end

endmodule

// File: rtl/boot_image_sender.sv
// rtl/boot_image_sender.sv - streams a sync/length header, ROM image bytes and checksum over UART
module boot_image_sender
  import boot_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       image_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              busy,
  output logic              done,
  output logic              uart_tx
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  state_t            r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_cnt;
  logic [1:0]        r_hdr;
  logic [7:0]        r_sum;
  logic [ADDR_W-1:0] r_addr;
  logic              r_sent;
  logic              r_busy;
  logic              r_done;
  logic              r_armed;

  logic       w_accept;
  logic       w_ready;
  logic       w_load;
  logic [7:0] w_byte;
  logic       w_last_data;

  assign w_accept    = start && r_armed && (r_state == ST_IDLE);
  assign w_last_data = (r_cnt == r_len - 16'd1);

  assign rom_addr = r_addr;
  assign busy     = r_busy;
  assign done     = r_done;

  // The sync byte is loaded on the accepting edge so the line starts the cycle busy rises.
  always_comb begin
    w_load = 1'b0;
    w_byte = SYNC_BYTE0;
    case (r_state)
      ST_IDLE: begin
        w_load = w_accept;
        w_byte = SYNC_BYTE0;
      end
      ST_HEADER: begin
        w_load = w_ready;
        case (r_hdr)
          2'd1:    w_byte = SYNC_BYTE1;
          2'd2:    w_byte = r_len[7:0];
          default: w_byte = r_len[15:8];
        endcase
      end
      ST_DATA: begin
        w_load = w_ready;
        w_byte = rom_data;
      end
      ST_CHECKSUM: begin
        w_load = w_ready && !r_sent;
        w_byte = r_sum;
      end
      default: begin
        w_load = 1'b0;
        w_byte = SYNC_BYTE0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_len   <= 16'd0;
      r_cnt   <= 16'd0;
      r_hdr   <= 2'd0;
      r_sum   <= 8'd0;
      r_addr  <= '0;
      r_sent  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_len   <= image_len;
            r_cnt   <= 16'd0;
            r_hdr   <= 2'd1;
            r_sum   <= 8'd0;
            r_addr  <= '0;
            r_sent  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (w_ready) begin
            if (r_hdr == 2'd3) begin
              r_state <= (r_len == 16'd0) ? ST_CHECKSUM : ST_DATA;
            end else begin
              r_hdr <= r_hdr + 2'd1;
            end
          end
        end
        ST_DATA: begin
          // Address moves as soon as a byte is taken, so the next one is stable through the stop bit.
          if (w_ready) begin
            r_sum <= r_sum + rom_data;
            r_cnt <= r_cnt + 16'd1;
            if (w_last_data) begin
              r_state <= ST_CHECKSUM;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        ST_CHECKSUM: begin
          if (w_ready) begin
            if (r_sent) begin
              r_state <= ST_FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_sent <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          r_addr  <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .clock  (clock),
    .reset  (reset),
    .load   (w_load),
    .byte_in(w_byte),
    .ready  (w_ready),
    .tx     (uart_tx)
  );

endmodule

// File: tb/tb_boot_image_sender.sv
// tb/tb_boot_image_sender.sv - scoreboard bench decoding the UART line against expected frames
module tb_boot_image_sender;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] image_len = 16'd0;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic        busy;
  logic        done;
  logic        uart_tx;

  logic [7:0]  rom [0:4095];
  logic [7:0]  exp_q [$];
  int          cyc = 0;
  int          last_start = -1;
  int          n_checks = 0;
  int          n_errors = 0;

  boot_image_sender #(
    .CLK_FREQ(400),
    .BAUD    (100),
    .ADDR_W  (12)
  ) dut (
    .clock    (clk),
    .reset    (rst_n),
    .start    (start),
    .image_len(image_len),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .done     (done),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: decode each 8N1 byte at mid-bit and compare with the scoreboard head.
  initial begin : monitor
    logic       prev;
    logic       ok;
    logic [7:0] b;
    prev = 1'b1;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && prev && (uart_tx == 1'b0)) begin
        if (last_start >= 0) check("start_spacing", cyc - last_start, 40);
        last_start = cyc;
        ok = 1'b1;
        repeat (2) @(negedge clk);
        if (!rst_n) ok = 1'b0;
        if (ok) check("start_bit", uart_tx, 0);
        for (int i = 0; i < 8 && ok; i++) begin
          repeat (4) @(negedge clk);
          if (!rst_n) ok = 1'b0;
          b[i] = uart_tx;
        end
        if (ok) begin
          repeat (4) @(negedge clk);
          if (!rst_n) ok = 1'b0;
        end
        if (ok) begin
          check("stop_bit", uart_tx, 1);
          if (exp_q.size() == 0) check("byte_expected", exp_q.size(), 1);
          else check("uart_byte", b, exp_q.pop_front());
        end
      end
      prev = uart_tx;
    end
  end

  task automatic push_frame(input int len, output logic [7:0] sum);
    sum = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(len[7:0]);
    exp_q.push_back(len[15:8]);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(rom[i[11:0]]);
      sum = sum + rom[i[11:0]];
    end
    exp_q.push_back(sum);
  endtask

  task automatic run_frame(input int len, input bit hammer, output bit addr_moved);
    logic [7:0] sum;
    int         busy_cnt;
    int         c;
    bit         seen;
    push_frame(len, sum);
    last_start = -1;
    image_len  = len[15:0];
    busy_cnt   = 0;
    seen       = 1'b0;
    addr_moved = 1'b0;
    c          = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hammer) start = 1'b0;
    while (!seen && c < 20000) begin
      if (rom_addr != 12'd0) addr_moved = 1'b1;
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
        check("busy_low_with_done", busy, 0);
      end else begin
        if (busy) busy_cnt++;
        c++;
        @(negedge clk);
      end
    end
    check("done_seen", seen, 1);
    check("busy_cycles", busy_cnt, (len + 5) * 40);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    repeat (60) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("idle_after_frame", busy, 0);
  endtask

  initial begin : stimulus
    bit         moved;
    logic [7:0] sum;
    int         edges;
    logic       prev;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[0] = 8'h01;
    rom[1] = 8'h02;
    rom[2] = 8'hFF;

    repeat (3) @(negedge clk);
    check("reset_tx", uart_tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", rom_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(3, 1'b0, moved);
    check("len3_addr_used", moved, 1);

    run_frame(0, 1'b0, moved);
    check("len0_addr_still", moved, 0);

    run_frame(3, 1'b1, moved);
    run_frame(3, 1'b0, moved);

    // Reset during the second data byte (0x02) while in its d2=0 bit.
    push_frame(3, sum);
    last_start = -1;
    image_len  = 16'd3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (213) @(negedge clk);
    check("tx_low_before_reset", uart_tx, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_tx_high", uart_tx, 1);
    check("abort_busy_low", busy, 0);
    check("abort_addr_zero", rom_addr, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    prev  = uart_tx;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_tx != prev) edges++;
      prev = uart_tx;
    end
    check("no_resume_edges", edges, 0);
    check("no_resume_busy", busy, 0);
    check("no_resume_queue", exp_q.size(), 0);

    for (int i = 0; i < 4096; i++) rom[i] = i[7:0];
    run_frame(256, 1'b0, moved);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/boot_image_sender.md
BOOT_IMAGE_SENDER -- requirements
Module: boot_image_sender

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate.
REQ-003 SHALL have parameter ADDR_W, default 12, image ROM address width.
REQ-004 SHALL have port clock  input  1  single system clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to send one boot frame.
REQ-007 SHALL have port image_len  input  16  data byte count, sampled on the accepted start.
REQ-008 SHALL have port rom_addr  output  ADDR_W  image ROM byte address.
REQ-009 SHALL have port rom_data  input  8  ROM byte, valid exactly 1 cycle after rom_addr is presented.
REQ-010 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the final stop bit.
REQ-012 SHALL have port uart_tx  output  1  8N1 serial line to the FlexPRET bootloader RX, idle high.

Function
REQ-013 SHALL accept start only when busy is low; start while busy is ignored.
REQ-014 SHALL transmit frame bytes in this order: 0xA5, 0x5A, len[7:0], len[15:8], then image_len data bytes from ROM addresses 0..image_len-1, then a checksum byte.
REQ-015 SHALL compute checksum as the 8-bit modulo-256 sum of the data bytes only; it SHALL start at 0x00 for each frame.
REQ-016 SHALL send each byte as 8N1: start bit 0, data bits LSB first, stop bit 1.
REQ-017 SHALL hold each bit for CLKS_PER_BIT = (CLK_FREQ + BAUD/2)/BAUD clocks, which is 434 at the defaults.
REQ-018 SHALL place no idle bit between consecutive bytes: the next start bit begins the clock after the previous stop bit ends.
REQ-019 SHALL present the next data address during the current byte's stop bit, so rom_data is registered before the next start bit.
REQ-020 SHALL use top-level states IDLE, HEADER, DATA, CHECKSUM, FINISH.
- IDLE -> HEADER on accepted start.
- HEADER -> DATA after the 4th header byte when image_len != 0; HEADER -> CHECKSUM when image_len = 0.
- DATA -> CHECKSUM after byte image_len-1.
- CHECKSUM -> FINISH after the checksum stop bit.
- FINISH -> IDLE after 1 cycle, asserting done in that cycle.
REQ-021 SHALL send the header plus checksum 0x00 when image_len = 0 (5 bytes total).
REQ-022 SHALL produce ADDR_W-bit wrapping addresses when image_len > 2^ADDR_W; the length field is still sent unmodified.
REQ-023 SHALL keep uart_tx high at all times outside a start bit or a 0 data bit, and SHALL produce no glitches: uart_tx is driven from a flop.
REQ-024 SHALL take busy low and assert done in the same cycle; a start in that cycle is ignored.

Reset
REQ-025 SHALL, while reset is low, force uart_tx=1, busy=0, done=0, rom_addr=0, state=IDLE, all counters and the checksum to 0.
REQ-026 SHALL abort a frame on reset assertion mid-frame, driving the line high immediately (asynchronously); it SHALL NOT resume after release.
REQ-027 SHALL accept no start in the first cycle after reset deassertion.

Structure
REQ-028 SHALL place the sync constants 0xA5/0x5A, the top-level state enum and the CLKS_PER_BIT function in shared package boot_pkg.
REQ-029 SHALL instantiate one sub-module, uart_tx_serializer, with ports clock, reset, load, byte, ready and tx; it owns the baud counter and bit counter and is reusable elsewhere.

Verification
REQ-030 Bench SHALL override CLK_FREQ=400 and BAUD=100 (CLKS_PER_BIT=4) for all scenarios below.
REQ-031 Scenario: image_len=3, ROM = 0x01, 0x02, 0xFF, start -> line decodes A5 5A 03 00 01 02 FF 02; done pulses 1 cycle after the last stop bit; busy lasts 8*10*4 cycles.
REQ-032 Scenario: image_len=0 -> line decodes A5 5A 00 00 00; rom_addr is never advanced.
REQ-033 Scenario: start pulsed every cycle during a frame -> exactly one frame is sent; a second start after done sends a second identical frame.
REQ-034 Scenario: reset asserted in the middle of data byte 2 -> uart_tx=1 and busy=0 in the same cycle; after release, no further transitions on the line without a new start.
REQ-035 Scenario: image_len=256 with ROM[i]=i -> checksum byte 0x80; each start-bit edge is spaced exactly 40 clocks from the previous one.
